// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Quotient goes to o_lo, remainder to o_hi; o_busy stalls the pipeline while
// a division is in flight.
// Optional: define DIV_BY_ZERO_DETECT_EN to add o_div_by_zero and a short-cut
// path that skips the iterative phase when the divisor is zero.
//
// state | meaning
// IDLE  | waiting for i_start; outputs hold the last result
// CALC  | WIDTH shift-subtract iterations on operand magnitudes
// SIGN  | apply sign correction, register o_lo/o_hi, pulse o_done
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
`ifdef DIV_BY_ZERO_DETECT_EN
  ,
  output logic             o_div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
`ifdef DIV_BY_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Trial subtraction: shifted partial remainder against the divisor. When it
  // fits, the difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    trial   = shifted[WIDTH-1:0] - dvs_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lo_d      = lo_q;
    hi_d      = hi_q;
`ifdef DIV_BY_ZERO_DETECT_EN
    dbz_d     = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start && !i_cancel) begin
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
          // A zero divisor runs on the raw dividend with no sign correction,
          // so the natural result is LO = all ones, HI = original dividend.
          if (i_signed && (i_divisor != '0)) begin
            quo_d     = mag(i_dividend);
            dvs_d     = mag(i_divisor);
            neg_quo_d = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            neg_rem_d = i_dividend[WIDTH-1];
          end else begin
            quo_d     = i_dividend;
            dvs_d     = i_divisor;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end
`ifdef DIV_BY_ZERO_DETECT_EN
          dbz_d = 1'b0;
          if (i_divisor == '0) begin
            quo_d   = '1;
            rem_d   = i_dividend;
            state_d = SIGN;
          end
`endif
        end
      end
      CALC: begin
        if (i_cancel) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = fits ? trial : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = SIGN;
          end
        end
      end
      SIGN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!i_cancel) begin
          lo_d   = neg_quo_q ? -quo_q : quo_q;
          hi_d   = neg_rem_q ? -rem_q : rem_q;
          done_d = 1'b1;
`ifdef DIV_BY_ZERO_DETECT_EN
          dbz_d  = (dvs_q == '0);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_lo   = lo_q;
  assign o_hi   = hi_q;
`ifdef DIV_BY_ZERO_DETECT_EN
  assign o_div_by_zero = dbz_q;
`endif

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
Multi-cycle 32-bit divider for MIPS DIV/DIVU in the EXE stage. Produces the busy signal the pipeline controller uses to freeze all pipeline register enables while a division is in flight. Writes quotient to LO and remainder to HI. Computes one quotient bit per cycle with a restoring shift-subtract datapath.

Parameters:
WIDTH, 32, operand/result width in bits (counter width = clog2(WIDTH)).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_start  in  1  request a division using the current operands; sampled only when idle
i_signed  in  1  1 = DIV (two's complement), 0 = DIVU
i_dividend  in  WIDTH  rs operand
i_divisor  in  WIDTH  rt operand
i_cancel  in  1  abort the in-flight operation (exception flush)
o_busy  out  1  division in flight; feeds controller i_div_busy
o_done  out  1  one-cycle pulse when o_lo/o_hi update
o_lo  out  WIDTH  quotient
o_hi  out  WIDTH  remainder

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); all outputs registered.
- Reset: state=IDLE, o_busy=0, o_done=0, o_lo=0, o_hi=0, counter=0. Reset mid-operation discards all work with no o_done; o_lo/o_hi go to 0.
- States: IDLE, CALC, SIGN.
- IDLE: when i_start=1 at an edge, latch the operands and i_signed.
  - Signed mode: latch |dividend|, |divisor|, sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB].
  - Unsigned mode: latch raw operands, both signs = 0.
  - Clear partial remainder, set counter=0, go to CALC.
- CALC: each cycle, shift {rem, quo} left by 1, try rem - divisor on a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise set it to 0.
  - Counter increments; after WIDTH iterations (counter == WIDTH-1 at the edge), go to SIGN.
- SIGN: LO = sign_q ? -quo : quo; HI = sign_r ? -rem : rem. Register o_lo/o_hi, pulse o_done=1, go to IDLE.
- o_busy is high in CALC and SIGN. It rises the edge after start is accepted and stays high for WIDTH+1 = 33 cycles. It falls the same edge o_done rises.
- Latency: start accepted at edge N; o_done=1 and results valid in cycle N+34; a new start is accepted at edge N+34 earliest.
- i_start while busy: ignored, with no effect on in-flight operands.
- i_cancel (any non-IDLE state): return to IDLE at the next edge, o_busy=0, no o_done, o_lo/o_hi unchanged.
  - i_cancel and i_start together in IDLE: cancel wins, start is ignored.
- Divide by zero: the natural restoring result is used, and sign correction is bypassed.
  - LO = all ones (0xFFFFFFFF), HI = original dividend (not its magnitude).
  - Takes the full 34-cycle latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special case.
- o_lo/o_hi hold their last values between operations.

Optional Feature:
DIV_BY_ZERO_DETECT_EN
- Defined:
  - Adds output o_div_by_zero (1 bit, reset 0).
  - In IDLE, a start with divisor == 0 skips CALC and goes straight to SIGN. Results are the same (LO = 0xFFFFFFFF, HI = dividend); o_done pulses 2 cycles after start, and o_busy is high for 1 cycle.
  - o_div_by_zero is registered high with that o_done and holds until the next accepted start.
- Undefined: no extra port; divide by zero takes the full latency as described above.

Test Plan:
- DIVU 100 / 7, start at edge 0 -> o_busy high cycles 1-33, o_done pulse cycle 34, o_lo = 14, o_hi = 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> o_lo = 0xFFFFFFFD (-3), o_hi = 0xFFFFFFFF (-1). Also 7 / -2 -> o_lo = 0xFFFFFFFD, o_hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> o_lo = 0x80000000, o_hi = 0. DIVU 0xFFFFFFFF / 1 -> o_lo = 0xFFFFFFFF, o_hi = 0.
- DIVU 5 / 0 -> o_lo = 0xFFFFFFFF, o_hi = 5 after 34 cycles. With DIV_BY_ZERO_DETECT_EN, o_done at cycle 2 and o_div_by_zero = 1.
- Start 100/7, then pulse i_start with 9/3 at cycle 10 -> ignored; result still 14/2 at cycle 34.
- Start 100/7, i_cancel at cycle 12 -> o_busy = 0 at cycle 13, no o_done, o_lo/o_hi keep prior values. Repeat with reset=1 at cycle 12 -> all outputs 0 at cycle 13.
